mem_write_buffer: RTL and testbench



---
 rtl/mem_write_buffer_pkg.sv | 16 +
 rtl/mem_write_buffer_sync_fifo.sv | 64 ++++++
 rtl/mem_write_buffer.sv | 163 ++++++++++++++++
 tb/tb_mem_write_buffer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_buffer_pkg.sv
// rtl/mem_write_buffer_pkg.sv - shared FSM encoding and entry sizing for the posted-write buffer
package mem_write_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RACK = 2'd3
  } wbuf_state_e;

  // One queued write is {adr, dat, sel}.
  function automatic int entry_width(input int aw, input int dw);
    return aw + dw + dw / 8;
  endfunction

endpackage

// File: rtl/mem_write_buffer_sync_fifo.sv
// rtl/mem_write_buffer_sync_fifo.sv - register-array FIFO with first-word-fall-through head
module sync_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_write_buffer.sv
// rtl/mem_write_buffer.sv - posted-write buffer between the BIU master port and the memory bus switch
module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_stb_i,
  input  logic              s_we_i,
  input  logic [AW-1:0]     s_adr_i,
  input  logic [DW-1:0]     s_dat_i,
  input  logic [DW/8-1:0]   s_sel_i,
  output logic [DW-1:0]     s_dat_o,
  output logic              s_ack_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic              m_we_o,
  output logic [AW-1:0]     m_adr_o,
  output logic [DW-1:0]     m_dat_o,
  output logic [DW/8-1:0]   m_sel_o,
  input  logic [DW-1:0]     m_dat_i,
  input  logic              m_ack_i,
  output logic              empty_o
);

  localparam int SW = DW / 8;
  localparam int EW = entry_width(AW, DW);
  localparam int CW = $clog2(DEPTH) + 1;

  wbuf_state_e     state_q, state_d;
  logic            m_cyc_q, m_cyc_d;
  logic            m_stb_q, m_stb_d;
  logic            m_we_q,  m_we_d;
  logic [AW-1:0]   m_adr_q, m_adr_d;
  logic [DW-1:0]   m_dat_q, m_dat_d;
  logic [SW-1:0]   m_sel_q, m_sel_d;
  logic            s_ack_q, s_ack_d;
  logic [DW-1:0]   s_dat_q, s_dat_d;

  logic [EW-1:0]   fifo_din, fifo_dout;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            push, pop;
  logic [AW-1:0]   head_adr;
  logic [DW-1:0]   head_dat;
  logic [SW-1:0]   head_sel;

  assign fifo_din = {s_adr_i, s_dat_i, s_sel_i};
  assign {head_adr, head_dat, head_sel} = fifo_dout;

  // s_ack_q blocks a second push while the master still holds stb in its ack cycle.
  assign push = s_stb_i & s_we_i & ~fifo_full & ~s_ack_q;

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    m_cyc_d = m_cyc_q;
    m_stb_d = m_stb_q;
    m_we_d  = m_we_q;
    m_adr_d = m_adr_q;
    m_dat_d = m_dat_q;
    m_sel_d = m_sel_q;
    s_dat_d = s_dat_q;
    s_ack_d = push;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Queued writes always go first so a read never overtakes them.
        if (!fifo_empty) begin
          state_d = ST_WR;
          m_cyc_d = 1'b1;
          m_stb_d = 1'b1;
          m_we_d  = 1'b1;
          m_adr_d = head_adr;
          m_dat_d = head_dat;
          m_sel_d = head_sel;
        end else if (s_stb_i && !s_we_i && !s_ack_q) begin
          state_d = ST_RD;
          m_cyc_d = 1'b1;
          m_stb_d = 1'b1;
          m_we_d  = 1'b0;
          m_adr_d = s_adr_i;
          m_sel_d = s_sel_i;
        end
      end
      ST_WR: begin
        if (m_ack_i) begin
          pop     = 1'b1;
          m_cyc_d = 1'b0;
          m_stb_d = 1'b0;
          m_we_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (m_ack_i) begin
          s_dat_d = m_dat_i;
          m_cyc_d = 1'b0;
          m_stb_d = 1'b0;
          state_d = ST_RACK;
        end
      end
      ST_RACK: begin
        s_ack_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      m_cyc_q <= 1'b0;
      m_stb_q <= 1'b0;
      m_we_q  <= 1'b0;
      m_adr_q <= '0;
      m_dat_q <= '0;
      m_sel_q <= '0;
      s_ack_q <= 1'b0;
      s_dat_q <= '0;
    end else begin
      state_q <= state_d;
      m_cyc_q <= m_cyc_d;
      m_stb_q <= m_stb_d;
      m_we_q  <= m_we_d;
      m_adr_q <= m_adr_d;
      m_dat_q <= m_dat_d;
      m_sel_q <= m_sel_d;
      s_ack_q <= s_ack_d;
      s_dat_q <= s_dat_d;
    end
  end

  assign m_cyc_o = m_cyc_q;
  assign m_stb_o = m_stb_q;
  assign m_we_o  = m_we_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;
  assign m_sel_o = m_sel_q;
  assign s_ack_o = s_ack_q;
  assign s_dat_o = s_dat_q;
  assign empty_o = (fifo_count == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_mem_write_buffer.sv
// tb/tb_mem_write_buffer.sv - self-checking bench for mem_write_buffer against a posted-write memory model
module tb_mem_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } ent_t;

  logic        clk_i   = 1'b0;
  logic        rst_i   = 1'b1;
  logic        s_stb_i = 1'b0;
  logic        s_we_i  = 1'b0;
  logic [31:0] s_adr_i = '0;
  logic [31:0] s_dat_i = '0;
  logic [3:0]  s_sel_i = '0;
  logic [31:0] m_dat_i = '0;
  logic        m_ack_i = 1'b0;
  logic [31:0] s_dat_o;
  logic        s_ack_o;
  logic        m_cyc_o, m_stb_o, m_we_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [3:0]  m_sel_o;
  logic        empty_o;

  mem_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_sel_i(s_sel_i),
    .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_sel_o(m_sel_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  // main-process state
  ent_t        exp_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  int          n_issued = 0;
  int          rd_idx   = 0;
  int          ds_lat   = 0;
  bit          ds_hold  = 1'b0;
  bit          rd_force = 1'b0;
  logic [31:0] rd_force_val = '0;

  // responder-process state
  ent_t        obs_arr [0:255];
  logic [31:0] ds_mem [logic [31:0]];
  int          n_obs    = 0;
  int          n_txn    = 0;
  int          stab_err = 0;
  int          rd_gap   = -1;
  int          wcnt     = 0;
  logic [68:0] snap     = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = dat[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ds_rd(input logic [31:0] a);
    return ds_mem.exists(a) ? ds_mem[a] : 32'h0;
  endfunction

  // Downstream memory slave: acks ds_lat cycles after stb, logs writes, serves reads.
  always @(negedge clk_i) begin
    if (rst_i || !(m_cyc_o && m_stb_o)) begin
      m_ack_i = 1'b0;
      m_dat_i = $urandom;
      wcnt    = 0;
    end else begin
      if (wcnt == 0) begin
        n_txn++;
        snap = {m_we_o, m_adr_o, m_dat_o, m_sel_o};
        if (!m_we_o) rd_gap = n_issued - n_obs;
      end else if ({m_we_o, m_adr_o, m_dat_o, m_sel_o} !== snap) begin
        stab_err++;
      end
      if (!ds_hold && wcnt >= ds_lat) begin
        m_ack_i = 1'b1;
        if (m_we_o) begin
          obs_arr[n_obs] = {m_adr_o, m_dat_o, m_sel_o};
          n_obs++;
          ds_mem[m_adr_o] = merge(ds_rd(m_adr_o), m_dat_o, m_sel_o);
        end else begin
          m_dat_i = rd_force ? rd_force_val : ds_rd(m_adr_o);
        end
      end else begin
        m_ack_i = 1'b0;
        m_dat_i = $urandom;
      end
      wcnt++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!s_ack_o && lat < 60);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat);
    exp_q.push_back({a, d, s});
    n_issued++;
    ref_mem[a] = merge(ref_rd(a), d, s);
    s_stb_i = 1'b1; s_we_i = 1'b1; s_adr_i = a; s_dat_i = d; s_sel_i = s;
    wait_ack(lat);
    s_stb_i = 1'b0; s_we_i = 1'b0;
    tick();
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = a; s_sel_i = 4'hF;
    wait_ack(lat);
    d = s_dat_o;
    s_stb_i = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!empty_o && n < 300) begin
      tick();
      n++;
    end
    chk(tag, empty_o, 1'b1);
  endtask

  task automatic drain_check(input string tag);
    ent_t e;
    while (rd_idx < n_obs) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk($sformatf("%s_entry%0d", tag, rd_idx), obs_arr[rd_idx], e);
      rd_idx++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int          lat;
    int          cnt;
    int          base;
    logic [31:0] rd;
    logic [31:0] a;

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("reset_outputs", {s_ack_o, s_dat_o, m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_dat_o, m_sel_o, empty_o},
        {1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 4'h0, 1'b1});

    // single write, 3-cycle downstream latency
    ds_lat = 3;
    do_write(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, lat);
    chk("t1_ack_lat", lat, 1);
    chk("t1_busy", empty_o, 1'b0);
    wait_empty("t1_empty");
    drain_check("t1");

    // fill to DEPTH with the downstream stalled, then a fifth write must wait for a pop
    ds_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_write(32'h10 + 32'(i * 4), $urandom, 4'hF, lat);
      chk($sformatf("t2_ack_lat%0d", i), lat, 1);
    end
    exp_q.push_back({32'h20, 32'hCAFE_0020, 4'hF});
    n_issued++;
    ref_mem[32'h20] = 32'hCAFE_0020;
    s_stb_i = 1'b1; s_we_i = 1'b1; s_adr_i = 32'h20; s_dat_i = 32'hCAFE_0020; s_sel_i = 4'hF;
    cnt = 0;
    repeat (6) begin
      tick();
      if (s_ack_o) cnt++;
    end
    chk("t2_full_no_ack", cnt, 0);
    ds_lat  = 0;
    ds_hold = 1'b0;
    wait_ack(lat);
    chk("t2_ack_after_pop", lat, 2);
    s_stb_i = 1'b0; s_we_i = 1'b0;
    tick();
    wait_empty("t2_empty");
    drain_check("t2");

    // write immediately followed by a read of the same address
    ds_lat = 2;
    do_write(32'h200, 32'h55AA_55AA, 4'hF, lat);
    do_read(32'h200, rd, lat);
    tick();
    chk("t3_read_after_drain", rd_gap, 0);
    chk("t3_read_data", rd, 32'h55AA_55AA);
    wait_empty("t3_empty");
    drain_check("t3");

    // best-case read latency on an empty buffer
    ds_lat       = 0;
    rd_force     = 1'b1;
    rd_force_val = 32'h1234_5678;
    do_read(32'h300, rd, lat);
    chk("t4_read_lat", lat, 3);
    chk("t4_read_data", rd, 32'h1234_5678);
    tick();
    chk("t4_ack_pulse", s_ack_o, 1'b0);
    rd_force = 1'b0;

    // sustained write stream with an always-ready downstream: never fills
    for (int i = 0; i < 20; i++) begin
      do_write(32'h1000 + 32'($urandom_range(0, 15) * 4), $urandom, 4'($urandom_range(1, 15)), lat);
      chk($sformatf("t5_ack_lat%0d", i), lat, 1);
    end
    wait_empty("t5_empty");
    drain_check("t5");

    // random mix of reads and writes with random downstream latency
    for (int i = 0; i < 40; i++) begin
      ds_lat = $urandom_range(0, 3);
      a = 32'h1000 + 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)), lat);
        chk($sformatf("mix_wr_acked%0d", i), lat < 60, 1'b1);
      end else begin
        do_read(a, rd, lat);
        tick();
        chk($sformatf("mix_rd_data%0d", i), rd, ref_rd(a));
        chk($sformatf("mix_rd_order%0d", i), rd_gap, 0);
      end
    end
    wait_empty("mix_empty");
    drain_check("mix");

    // reset while a write is on the bus with three entries queued
    ds_hold = 1'b1;
    for (int i = 0; i < 3; i++) do_write(32'h800 + 32'(i * 4), $urandom, 4'hF, lat);
    chk("t6_in_wr", {m_cyc_o, m_stb_o, m_we_o}, 3'b111);
    rst_i = 1'b1;
    tick();
    chk("t6_bus_dropped", {m_cyc_o, m_stb_o}, 2'b00);
    chk("t6_empty", empty_o, 1'b1);
    rst_i = 1'b0;
    exp_q.delete();
    n_issued = n_obs;
    rd_idx   = n_obs;
    base     = n_txn;
    ds_hold  = 1'b0;
    repeat (12) tick();
    chk("t6_no_new_txn", n_txn, base);
    chk("t6_idle_bus", {m_cyc_o, m_stb_o, s_ack_o}, 3'b000);

    chk("bus_stability", stab_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
